scan_8seg: RTL and testbench
============================

Name: scan_8seg

Overview:
- Multiplexed display scanner sitting directly upstream of the 8-segment decoder.
- Holds NDIGITS hex nibbles plus per-digit dot bits in a double-buffered display register.
- Time-slices them onto one shared tetrade/dot/oe bus and drives a one-hot digit select.
- Blanking gap at the start of each slot prevents ghosting; new data commits only at frame boundaries, so frames never tear.

Parameters:
- NDIGITS, 4, number of multiplexed digits (>=1)
- PRESCALE, 1200, clock cycles per digit slot (>=2)
- BLANK, 16, cycles at start of each slot with display off (0 <= BLANK < PRESCALE)

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- en  input  1  scan enable
- we  input  1  write strobe for new display contents
- wdata  input  4*NDIGITS  nibbles; digit i = wdata[4i+3:4i]
- wdots  input  NDIGITS  dot bit per digit
- pending  output  1  write captured, not yet committed
- oe  output  1  decoder output enable
- tetrade  output  4  nibble of active digit
- dot  output  1  dot of active digit
- digit  output  NDIGITS  one-hot digit select, active-high
- frame  output  1  one-cycle pulse at end of each full scan

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- State: slot counter cnt (0..PRESCALE-1), digit index idx (0..NDIGITS-1), display regs disp/dots, shadow regs shd/shdots, pending flag.
- Reset (rst=1 at a clk edge): cnt=0, idx=0, disp=0, dots=0, shd=0, shdots=0, pending=0, all outputs 0. Reset overrides everything, including we.
- Counting (en=1): cnt increments each clock. At cnt=PRESCALE-1, cnt wraps to 0 and idx increments; idx wraps from NDIGITS-1 to 0.
- Frame boundary = cnt=PRESCALE-1 and idx=NDIGITS-1.
- All outputs are flops loaded each edge from decode of the current cnt/idx/disp, so outputs lag the counters by exactly one clock.
- Decode:
  - cnt < BLANK: oe=0, digit=0, tetrade=0, dot=0.
  - Otherwise: oe=1, digit=1<<idx, tetrade=disp[idx], dot=dots[idx].
- Per slot: exactly BLANK blank cycles followed by PRESCALE-BLANK lit cycles.
- First oe rise is at rising edge BLANK+1 after rst deasserts.
- frame: registered pulse, high for one cycle on the edge after the frame boundary.
- Write handshake (en=1):
  - we=1 captures wdata/wdots into shd/shdots and sets pending=1. A repeated we overwrites shd; last write wins.
  - At a frame boundary with pending=1 and we=0: disp<=shd, dots<=shdots, pending<=0.
  - At a frame boundary with we=1: disp/dots take wdata/wdots directly (write-through), shd also updated, pending stays 0.
- en=0:
  - cnt and idx are synchronously cleared to 0; oe, digit, tetrade and dot are registered 0; frame=0.
  - Any pending shadow commits immediately (disp<=shd, pending<=0).
  - we with en=0 writes disp/dots directly; pending stays 0.
- en rising: scan restarts at idx 0, cnt 0; timing is identical to release from reset.

Optional Feature:
Macro: SCAN_8SEG_LZB_EN (leading-zero blanking).
- Defined: scanning from idx NDIGITS-1 down, each digit whose nibble is 0 and dot is 0 is suppressed until the first digit that fails that test. A suppressed digit's slot runs with oe=0 and digit=0 for all PRESCALE cycles; slot timing is unchanged.
- Digit 0 is never suppressed.
- The suppression mask is computed from disp/dots, so it changes only when disp changes.
- Undefined: all digits are lit as described above.

Test Plan (NDIGITS=4, PRESCALE=8, BLANK=2):
- Reset release, en=1: oe=0 at edges 1-2, oe=1 at edges 3-8 with digit=0001, tetrade=0; edges 11-16 give digit=0010; frame pulses once per 32 cycles.
- we with wdata=16'h1234, wdots=4'b0001 during idx=1: pending=1 and tetrade stays 0 for the rest of the frame. After the frame pulse, pending=0; the lit sequence is digit0=4 dot=1, digit1=3, digit2=2, digit3=1.
- we exactly at the frame boundary with 16'hABCD: next frame shows D,C,B,A immediately and pending never rises.
- Two we writes (16'h1111 then 16'h2222) in one frame: only 2222 is ever displayed.
- en dropped mid-slot at idx=2: oe/digit go 0 on the next edge, pending data commits. en restored: blank for 2 edges, then digit=0001.
- rst mid-frame with pending=1: all outputs 0, display cleared, pending=0, and the earlier write never appears.
- SCAN_8SEG_LZB_EN, disp=16'h0050, dots=0: digits 3 and 2 are dark for whole slots, digit1=5 and digit0=0 are lit. With dots=4'b1000, all four digits are lit.

Source files
------------

// File: rtl/scan_8seg.sv
// Multiplexed hex/dot display scanner with double-buffered display contents.
// Optional leading-zero blanking when SCAN_8SEG_LZB_EN is defined.
module scan_8seg #(
  parameter int unsigned NDIGITS  = 4,
  parameter int unsigned PRESCALE = 1200,
  parameter int unsigned BLANK    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   we,
  input  logic [4*NDIGITS-1:0]   wdata,
  input  logic [NDIGITS-1:0]     wdots,
  output logic                   pending,
  output logic                   oe,
  output logic [3:0]             tetrade,
  output logic                   dot,
  output logic [NDIGITS-1:0]     digit,
  output logic                   frame
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic [4*NDIGITS-1:0]   disp_q, shd_q;
  logic [NDIGITS-1:0]     dots_q, shdots_q;
  logic [NDIGITS-1:0]     sup;
  logic                   slot_end, frame_end, lit;

  assign slot_end  = (cnt_q == CW'(PRESCALE - 1));
  assign frame_end = slot_end && (idx_q == IW'(NDIGITS - 1));
  assign lit       = (cnt_q >= CW'(BLANK)) && !sup[idx_q];

`ifdef SCAN_8SEG_LZB_EN
  logic lead;

  // Suppress from the top digit down while nibble and dot are both zero; digit 0 always lit.
  always_comb begin
    lead = 1'b1;
    sup  = '0;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      lead   = lead && (disp_q[4*i +: 4] == 4'h0) && !dots_q[i];
      sup[i] = lead;
    end
  end
`else
  assign sup = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      dots_q   <= '0;
      shd_q    <= '0;
      shdots_q <= '0;
      pending  <= 1'b0;
      oe       <= 1'b0;
      tetrade  <= 4'h0;
      dot      <= 1'b0;
      digit    <= '0;
      frame    <= 1'b0;
    end else if (!en) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      oe      <= 1'b0;
      tetrade <= 4'h0;
      dot     <= 1'b0;
      digit   <= '0;
      frame   <= 1'b0;
      pending <= 1'b0;
      // Scanning is stopped, so there is no frame to tear: write straight through.
      if (we) begin
        disp_q   <= wdata;
        dots_q   <= wdots;
        shd_q    <= wdata;
        shdots_q <= wdots;
      end else if (pending) begin
        disp_q <= shd_q;
        dots_q <= shdots_q;
      end
    end else begin
      cnt_q <= slot_end ? '0 : cnt_q + CW'(1);
      if (slot_end) begin
        idx_q <= (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
      oe      <= lit;
      digit   <= lit ? (NDIGITS'(1) << idx_q) : '0;
      tetrade <= lit ? disp_q[{idx_q, 2'b00} +: 4] : 4'h0;
      dot     <= lit && dots_q[idx_q];
      frame   <= frame_end;
      if (we) begin
        shd_q    <= wdata;
        shdots_q <= wdots;
        if (frame_end) begin
          disp_q  <= wdata;
          dots_q  <= wdots;
          pending <= 1'b0;
        end else begin
          pending <= 1'b1;
        end
      end else if (frame_end && pending) begin
        disp_q  <= shd_q;
        dots_q  <= shdots_q;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scan_8seg.sv
// Directed self-checking bench for scan_8seg (NDIGITS=4, PRESCALE=8, BLANK=2).
module tb_scan_8seg;

  localparam int unsigned ND = 4;
  localparam int unsigned PS = 8;
  localparam int unsigned BL = 2;

  logic        clk = 1'b0;
  logic        rst, en, we;
  logic [15:0] wdata;
  logic [3:0]  wdots;
  logic        pending, oe, dot, frame;
  logic [3:0]  tetrade;
  logic [3:0]  digit;

  int checks   = 0;
  int failures = 0;
  int t        = 0;

  always #5 clk = ~clk;

  scan_8seg #(.NDIGITS(ND), .PRESCALE(PS), .BLANK(BL)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .we      (we),
    .wdata   (wdata),
    .wdots   (wdots),
    .pending (pending),
    .oe      (oe),
    .tetrade (tetrade),
    .dot     (dot),
    .digit   (digit),
    .frame   (frame)
  );

  // t counts enabled edges since restart; outputs after edge t reflect position t-1.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  function automatic int pidx();
    return ((t - 1) / PS) % ND;
  endfunction

  function automatic bit plit();
    return ((t - 1) % PS) >= BL;
  endfunction

  function automatic bit lz(input logic [15:0] v, input logic [3:0] d, input int i);
`ifdef SCAN_8SEG_LZB_EN
    if (i == 0) return 1'b0;
    for (int j = ND - 1; j >= i; j--) begin
      if (v[j*4 +: 4] != 4'h0 || d[j]) return 1'b0;
    end
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic expv(input logic [15:0] cur, input logic [3:0] curd, output logic eoe,
                      output logic [3:0] edig, output logic [3:0] etet, output logic edot);
    eoe  = plit() && !lz(cur, curd, pidx());
    edig = eoe ? (4'b0001 << pidx()) : 4'b0000;
    etet = eoe ? cur[pidx()*4 +: 4] : 4'h0;
    edot = eoe && curd[pidx()];
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; we = 1'b0; wdata = '0; wdots = '0;
    tick();
    tick();
    rst = 1'b0;
    t   = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; we = 1'b1; wdata = 16'hFFFF; wdots = 4'hF;
    tick();
    tick();
    checks++;
    if ({pending, oe, tetrade, dot, digit, frame} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {pending, oe, tetrade, dot, digit, frame});
    end
    we = 1'b0;
    rst = 1'b0;
    t = 0;
  endtask

  task automatic test_scan();
    logic eoe, edot;
    logic [3:0] edig, etet;
    int frames = 0;
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      tick();
      expv(16'h0000, 4'h0, eoe, edig, etet, edot);
      checks++;
      if (oe !== eoe || digit !== edig || tetrade !== etet) begin
        failures++;
        $display("FAIL scan t=%0d got oe=%b dig=%b tet=%h exp oe=%b dig=%b tet=%h",
                 t, oe, digit, tetrade, eoe, edig, etet);
      end
      checks++;
      if (frame !== (t % 32 == 0)) begin
        failures++;
        $display("FAIL scan_frame t=%0d got=%b exp=%b", t, frame, (t % 32 == 0));
      end
      if (frame === 1'b1) frames++;
    end
    checks++;
    if (frames != 2) begin
      failures++;
      $display("FAIL scan_frame_count got=%0d exp=2", frames);
    end
  endtask

  // we asserted on edge wk with value v; new data visible from edge 33 on.
  task automatic run_write(input string name, input int wk, input logic [15:0] v,
                           input logic [3:0] vd, input int wk2, input logic [15:0] v2,
                           input logic [15:0] shown, input logic [3:0] shownd,
                           input int pend_from);
    logic eoe, edot, epend;
    logic [3:0] edig, etet;
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      we    = (k == wk) || (k == wk2);
      wdata = (k == wk2) ? v2 : v;
      wdots = vd;
      tick();
      if (t > 32) expv(shown, shownd, eoe, edig, etet, edot);
      else expv(16'h0000, 4'h0, eoe, edig, etet, edot);
      epend = (pend_from > 0) && (t >= pend_from) && (t < 32);
      checks++;
      if (oe !== eoe || digit !== edig || tetrade !== etet || dot !== edot) begin
        failures++;
        $display("FAIL %s t=%0d got oe=%b dig=%b tet=%h dot=%b exp oe=%b dig=%b tet=%h dot=%b",
                 name, t, oe, digit, tetrade, dot, eoe, edig, etet, edot);
      end
      checks++;
      if (pending !== epend) begin
        failures++;
        $display("FAIL %s_pending t=%0d got=%b exp=%b", name, t, pending, epend);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_write();
    run_write("write", 11, 16'h1234, 4'b0001, 0, 16'h0000, 16'h1234, 4'b0001, 11);
  endtask

  task automatic test_boundary();
    run_write("boundary", 32, 16'hABCD, 4'b0000, 0, 16'h0000, 16'hABCD, 4'b0000, 0);
  endtask

  task automatic test_back_to_back();
    run_write("b2b", 5, 16'h1111, 4'b0000, 20, 16'h2222, 16'h2222, 4'b0000, 5);
  endtask

  task automatic test_en_drop();
    logic eoe, edot;
    logic [3:0] edig, etet;
    do_reset();
    we = 1'b1; wdata = 16'h5678; wdots = 4'b0010;
    tick();
    we = 1'b0;
    repeat (19) tick();
    checks++;
    if (oe !== 1'b1 || digit !== 4'b0100 || pending !== 1'b1) begin
      failures++;
      $display("FAIL en_mid got oe=%b dig=%b pend=%b exp oe=1 dig=0100 pend=1", oe, digit, pending);
    end
    en = 1'b0;
    tick();
    checks++;
    if (oe !== 1'b0 || digit !== 4'b0000 || pending !== 1'b0 || frame !== 1'b0) begin
      failures++;
      $display("FAIL en_drop got oe=%b dig=%b pend=%b frm=%b exp 0 0000 0 0",
               oe, digit, pending, frame);
    end
    tick();
    en = 1'b1;
    t = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      expv(16'h5678, 4'b0010, eoe, edig, etet, edot);
      checks++;
      if (oe !== eoe || digit !== edig || tetrade !== etet || dot !== edot) begin
        failures++;
        $display("FAIL en_restart t=%0d got oe=%b dig=%b tet=%h dot=%b exp oe=%b dig=%b tet=%h dot=%b",
                 t, oe, digit, tetrade, dot, eoe, edig, etet, edot);
      end
    end
    // Write with scanning stopped goes straight to the display.
    en = 1'b0; we = 1'b1; wdata = 16'h9ABC; wdots = 4'b0100;
    tick();
    we = 1'b0;
    checks++;
    if (pending !== 1'b0 || oe !== 1'b0) begin
      failures++;
      $display("FAIL en_off_write got pend=%b oe=%b exp pend=0 oe=0", pending, oe);
    end
    en = 1'b1;
    t = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      expv(16'h9ABC, 4'b0100, eoe, edig, etet, edot);
      checks++;
      if (oe !== eoe || digit !== edig || tetrade !== etet || dot !== edot || pending !== 1'b0) begin
        failures++;
        $display("FAIL en_direct t=%0d got oe=%b dig=%b tet=%h dot=%b pend=%b exp oe=%b dig=%b tet=%h dot=%b pend=0",
                 t, oe, digit, tetrade, dot, pending, eoe, edig, etet, edot);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic eoe, edot;
    logic [3:0] edig, etet;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      we = (k == 5); wdata = 16'h7777; wdots = 4'b1111;
      tick();
    end
    we = 1'b0;
    checks++;
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pending_before got=%b exp=1", pending);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({pending, oe, tetrade, dot, digit, frame} !== 12'h000) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h exp=000", {pending, oe, tetrade, dot, digit, frame});
    end
    rst = 1'b0;
    t = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      expv(16'h0000, 4'h0, eoe, edig, etet, edot);
      checks++;
      if (oe !== eoe || tetrade !== 4'h0 || dot !== 1'b0 || pending !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_after t=%0d got oe=%b tet=%h dot=%b pend=%b exp oe=%b tet=0 dot=0 pend=0",
                 t, oe, tetrade, dot, pending, eoe);
      end
    end
  endtask

`ifdef SCAN_8SEG_LZB_EN
  task automatic test_lzb();
    logic [3:0] dl [2];
    logic       eoe;
    logic [3:0] edig, etet;
    logic       edot;
    dl[0] = 4'b0000;
    dl[1] = 4'b1000;
    for (int m = 0; m < 2; m++) begin
      en = 1'b0; we = 1'b1; wdata = 16'h0050; wdots = dl[m];
      tick();
      we = 1'b0; en = 1'b1; t = 0;
      for (int k = 1; k <= 32; k++) begin
        tick();
        eoe  = plit() && ((m == 1) || (pidx() < 2));
        edig = eoe ? (4'b0001 << pidx()) : 4'b0000;
        etet = (eoe && pidx() == 1) ? 4'h5 : 4'h0;
        edot = eoe && (m == 1) && (pidx() == 3);
        checks++;
        if (oe !== eoe || digit !== edig || tetrade !== etet || dot !== edot) begin
          failures++;
          $display("FAIL lzb m=%0d t=%0d got oe=%b dig=%b tet=%h dot=%b exp oe=%b dig=%b tet=%h dot=%b",
                   m, t, oe, digit, tetrade, dot, eoe, edig, etet, edot);
        end
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; wdata = '0; wdots = '0;
    test_reset();
    test_scan();
    test_write();
    test_boundary();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
`ifdef SCAN_8SEG_LZB_EN
    test_lzb();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
